sevseg_mux_driver: RTL and testbench

//  Time-multiplexed N-digit hex seven-segment display driver, active-low segments and anodes.
//  - Latches a packed word of 4-bit digit values and scans the digits one at a time.
//  - Updates the displayed value only at frame boundaries, so no digit shows a mix of old and new data.
//  - Sits between core logic and the board's common-anode display pins.

---
 rtl/sevseg_mux_driver.sv | 152 +++++++++++++++
 tb/tb_sevseg_mux_driver.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/sevseg_mux_driver.sv
// Time-multiplexed N-digit hex seven-segment driver with active-low segments and anodes.
// Defining SEVSEG_DP_EN adds a shadowed, active-low decimal-point path (dp_in/dp).
module sevseg_mux_driver #(
  parameter int N_DIGITS    = 8,
  parameter int REFRESH_DIV = 100000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [4*N_DIGITS-1:0] data,
  input  logic                  blank,
`ifdef SEVSEG_DP_EN
  input  logic [N_DIGITS-1:0]   dp_in,
  output logic                  dp,
`endif
  output logic [6:0]            seg,
  output logic [N_DIGITS-1:0]   an,
  output logic                  frame_tick
);

  localparam int CNT_W = (REFRESH_DIV >= 2) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (N_DIGITS >= 2) ? $clog2(N_DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);

  if (N_DIGITS < 1 || N_DIGITS > 16) begin : g_bad_n_digits
    $error("sevseg_mux_driver: N_DIGITS=%0d outside 1..16", N_DIGITS);
  end
  if (REFRESH_DIV < 2) begin : g_bad_refresh_div
    $error("sevseg_mux_driver: REFRESH_DIV=%0d must be >= 2", REFRESH_DIV);
  end

  function automatic logic [6:0] decode(input logic [3:0] v);
    case (v)
      4'h0:    return 7'h01;
      4'h1:    return 7'h4F;
      4'h2:    return 7'h12;
      4'h3:    return 7'h06;
      4'h4:    return 7'h4C;
      4'h5:    return 7'h24;
      4'h6:    return 7'h20;
      4'h7:    return 7'h0F;
      4'h8:    return 7'h00;
      4'h9:    return 7'h04;
      4'hA:    return 7'h08;
      4'hB:    return 7'h60;
      4'hC:    return 7'h31;
      4'hD:    return 7'h42;
      4'hE:    return 7'h30;
      default: return 7'h38;
    endcase
  endfunction

  logic [CNT_W-1:0]      div_cnt_q, div_cnt_d;
  logic [IDX_W-1:0]      digit_idx_q, digit_idx_d;
  logic [4*N_DIGITS-1:0] pend_reg_q, pend_reg_d;
  logic                  pend_valid_q, pend_valid_d;
  logic [4*N_DIGITS-1:0] disp_reg_q, disp_reg_d;
  logic [6:0]            seg_q, seg_d;
  logic [N_DIGITS-1:0]   an_q, an_d;
  logic                  frame_tick_q, frame_tick_d;
  logic                  tc, wrap, dead;
  logic [3:0]            digit_val;
`ifdef SEVSEG_DP_EN
  logic [N_DIGITS-1:0]   pend_dp_q, pend_dp_d;
  logic [N_DIGITS-1:0]   disp_dp_q, disp_dp_d;
  logic                  dp_q, dp_d;
`endif

  always_comb begin
    tc           = (div_cnt_q == CNT_LAST);
    wrap         = tc && (digit_idx_q == IDX_LAST);
    div_cnt_d    = tc ? '0 : div_cnt_q + 1'b1;
    digit_idx_d  = digit_idx_q;
    if (tc) begin
      digit_idx_d = (digit_idx_q == IDX_LAST) ? '0 : digit_idx_q + 1'b1;
    end

    // Shadow transfer happens before the write so a same-cycle write stays pending.
    pend_reg_d   = pend_reg_q;
    pend_valid_d = pend_valid_q;
    disp_reg_d   = disp_reg_q;
`ifdef SEVSEG_DP_EN
    pend_dp_d    = pend_dp_q;
    disp_dp_d    = disp_dp_q;
`endif
    if (wrap && pend_valid_q) begin
      disp_reg_d   = pend_reg_q;
      pend_valid_d = 1'b0;
`ifdef SEVSEG_DP_EN
      disp_dp_d    = pend_dp_q;
`endif
    end
    if (wr_en) begin
      pend_reg_d   = data;
      pend_valid_d = 1'b1;
`ifdef SEVSEG_DP_EN
      pend_dp_d    = dp_in;
`endif
    end

    // First cycle of every slot is dark to avoid ghosting between digits.
    dead         = blank || (div_cnt_q == '0);
    digit_val    = disp_reg_q[{digit_idx_q, 2'b00} +: 4];
    seg_d        = dead ? 7'h7F : decode(digit_val);
    an_d         = dead ? '1 : ~(N_DIGITS'(1) << digit_idx_q);
    frame_tick_d = wrap;
`ifdef SEVSEG_DP_EN
    dp_d         = dead ? 1'b1 : ~disp_dp_q[digit_idx_q];
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q    <= '0;
      digit_idx_q  <= '0;
      pend_reg_q   <= '0;
      pend_valid_q <= 1'b0;
      disp_reg_q   <= '0;
      seg_q        <= 7'h7F;
      an_q         <= '1;
      frame_tick_q <= 1'b0;
`ifdef SEVSEG_DP_EN
      pend_dp_q    <= '0;
      disp_dp_q    <= '0;
      dp_q         <= 1'b1;
`endif
    end else begin
      div_cnt_q    <= div_cnt_d;
      digit_idx_q  <= digit_idx_d;
      pend_reg_q   <= pend_reg_d;
      pend_valid_q <= pend_valid_d;
      disp_reg_q   <= disp_reg_d;
      seg_q        <= seg_d;
      an_q         <= an_d;
      frame_tick_q <= frame_tick_d;
`ifdef SEVSEG_DP_EN
      pend_dp_q    <= pend_dp_d;
      disp_dp_q    <= disp_dp_d;
      dp_q         <= dp_d;
`endif
    end
  end

  assign seg        = seg_q;
  assign an         = an_q;
  assign frame_tick = frame_tick_q;
`ifdef SEVSEG_DP_EN
  assign dp         = dp_q;
`endif

endmodule

// File: tb/tb_sevseg_mux_driver.sv
// Directed bench for sevseg_mux_driver with N_DIGITS=4, REFRESH_DIV=4 (16-cycle frames).
// cyc counts rising edges since reset release; outputs are sampled on the falling edge.
module tb_sevseg_mux_driver;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en;
  logic [15:0] data;
  logic        blank;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        frame_tick;
`ifdef SEVSEG_DP_EN
  logic [3:0]  dp_in;
  logic        dp;
`endif

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  sevseg_mux_driver #(.N_DIGITS(4), .REFRESH_DIV(4)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .data(data), .blank(blank),
`ifdef SEVSEG_DP_EN
    .dp_in(dp_in), .dp(dp),
`endif
    .seg(seg), .an(an), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: return 7'h01;  4'h1: return 7'h4F;  4'h2: return 7'h12;  4'h3: return 7'h06;
      4'h4: return 7'h4C;  4'h5: return 7'h24;  4'h6: return 7'h20;  4'h7: return 7'h0F;
      4'h8: return 7'h00;  4'h9: return 7'h04;  4'hA: return 7'h08;  4'hB: return 7'h60;
      4'hC: return 7'h31;  4'hD: return 7'h42;  4'hE: return 7'h30;  default: return 7'h38;
    endcase
  endfunction

  // Output after edge k reflects the state after edge k-1: slot (k-1)/4, dark when (k-1)%4==0.
  function automatic logic [3:0] exp_an(input int k);
    int m = k - 1;
    logic [3:0] one = 4'b0001;
    if (m % 4 == 0) return 4'hF;
    return ~(one << ((m / 4) % 4));
  endfunction

  function automatic logic [6:0] exp_seg(input int k, input logic [15:0] w);
    int m = k - 1;
    int idx = (m / 4) % 4;
    if (m % 4 == 0) return 7'h7F;
    return hex7(w[4*idx +: 4]);
  endfunction

  function automatic logic exp_ft(input int k);
    return (k % 16 == 0);
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; wr_en = 1'b0; blank = 1'b0; data = '0;
`ifdef SEVSEG_DP_EN
    dp_in = '0;
`endif
    repeat (3) @(negedge clk);
    checks++; if (seg !== 7'h7F) begin errors++; $display("[TB] FAIL reset_seg got=%h exp=7f", seg); end
    checks++; if (an !== 4'hF) begin errors++; $display("[TB] FAIL reset_an got=%h exp=f", an); end
    checks++; if (frame_tick !== 1'b0) begin errors++; $display("[TB] FAIL reset_ft got=%b exp=0", frame_tick); end
    rst_n = 1'b1;
  endtask

  task automatic test_idle_scan();
    int k;
    do begin
      @(negedge clk); k = cyc;
      checks++; if (an !== exp_an(k)) begin errors++; $display("[TB] FAIL idle_an k=%0d got=%h exp=%h", k, an, exp_an(k)); end
      checks++; if (seg !== exp_seg(k, 16'h0000)) begin errors++; $display("[TB] FAIL idle_seg k=%0d got=%h exp=%h", k, seg, exp_seg(k, 16'h0000)); end
      checks++; if (frame_tick !== exp_ft(k)) begin errors++; $display("[TB] FAIL idle_ft k=%0d got=%b exp=%b", k, frame_tick, exp_ft(k)); end
    end while (k < 20);
  endtask

  task automatic test_write_mid_frame();
    int k;
    logic [15:0] w;
    do begin
      wr_en = (cyc == 20); data = 16'h1A3F;
      @(negedge clk); k = cyc;
      w = ((k - 1) / 16 >= 2) ? 16'h1A3F : 16'h0000;
      checks++; if (an !== exp_an(k)) begin errors++; $display("[TB] FAIL mid_an k=%0d got=%h exp=%h", k, an, exp_an(k)); end
      checks++; if (seg !== exp_seg(k, w)) begin errors++; $display("[TB] FAIL mid_seg k=%0d got=%h exp=%h", k, seg, exp_seg(k, w)); end
      checks++; if (frame_tick !== exp_ft(k)) begin errors++; $display("[TB] FAIL mid_ft k=%0d got=%b exp=%b", k, frame_tick, exp_ft(k)); end
    end while (k < 48);
    wr_en = 1'b0;
  endtask

  task automatic test_two_writes();
    int k;
    logic [15:0] w;
    do begin
      wr_en = 1'b0;
      if (cyc == 50) begin wr_en = 1'b1; data = 16'h1111; end
      if (cyc == 54) begin wr_en = 1'b1; data = 16'h2222; end
      @(negedge clk); k = cyc;
      w = ((k - 1) / 16 >= 4) ? 16'h2222 : 16'h1A3F;
      checks++; if (an !== exp_an(k)) begin errors++; $display("[TB] FAIL two_an k=%0d got=%h exp=%h", k, an, exp_an(k)); end
      checks++; if (seg !== exp_seg(k, w)) begin errors++; $display("[TB] FAIL two_seg k=%0d got=%h exp=%h", k, seg, exp_seg(k, w)); end
      checks++; if (frame_tick !== exp_ft(k)) begin errors++; $display("[TB] FAIL two_ft k=%0d got=%b exp=%b", k, frame_tick, exp_ft(k)); end
    end while (k < 80);
    wr_en = 1'b0;
  endtask

  // 5555 is pending when 8888 arrives exactly on the wrap edge (edge 96).
  task automatic test_back_to_back();
    int k;
    int f;
    logic [15:0] w;
    do begin
      wr_en = 1'b0;
      if (cyc == 84) begin wr_en = 1'b1; data = 16'h5555; end
      if (cyc == 95) begin wr_en = 1'b1; data = 16'h8888; end
      @(negedge clk); k = cyc; f = (k - 1) / 16;
      w = (f <= 5) ? 16'h2222 : (f == 6) ? 16'h5555 : 16'h8888;
      checks++; if (an !== exp_an(k)) begin errors++; $display("[TB] FAIL wrapwr_an k=%0d got=%h exp=%h", k, an, exp_an(k)); end
      checks++; if (seg !== exp_seg(k, w)) begin errors++; $display("[TB] FAIL wrapwr_seg k=%0d got=%h exp=%h", k, seg, exp_seg(k, w)); end
      checks++; if (frame_tick !== exp_ft(k)) begin errors++; $display("[TB] FAIL wrapwr_ft k=%0d got=%b exp=%b", k, frame_tick, exp_ft(k)); end
    end while (k < 128);
    wr_en = 1'b0;
  endtask

  task automatic test_async_reset();
    int k;
    do begin
      wr_en = (cyc == 129); data = 16'h7777;
      @(negedge clk); k = cyc;
      checks++; if (seg !== exp_seg(k, 16'h8888)) begin errors++; $display("[TB] FAIL prerst_seg k=%0d got=%h exp=%h", k, seg, exp_seg(k, 16'h8888)); end
    end while (k < 138);
    wr_en = 1'b0;
    checks++; if (an !== 4'hB) begin errors++; $display("[TB] FAIL prerst_an_digit2 got=%h exp=b", an); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (an !== 4'hF) begin errors++; $display("[TB] FAIL async_an got=%h exp=f", an); end
    checks++; if (seg !== 7'h7F) begin errors++; $display("[TB] FAIL async_seg got=%h exp=7f", seg); end
    checks++; if (frame_tick !== 1'b0) begin errors++; $display("[TB] FAIL async_ft got=%b exp=0", frame_tick); end
    @(negedge clk);
    rst_n = 1'b1;
    // Lost pending 7777 must never appear; scan restarts at digit 0.
    do begin
      @(negedge clk); k = cyc;
      checks++; if (an !== exp_an(k)) begin errors++; $display("[TB] FAIL postrst_an k=%0d got=%h exp=%h", k, an, exp_an(k)); end
      checks++; if (seg !== exp_seg(k, 16'h0000)) begin errors++; $display("[TB] FAIL postrst_seg k=%0d got=%h exp=%h", k, seg, exp_seg(k, 16'h0000)); end
      checks++; if (frame_tick !== exp_ft(k)) begin errors++; $display("[TB] FAIL postrst_ft k=%0d got=%b exp=%b", k, frame_tick, exp_ft(k)); end
    end while (k < 32);
  endtask

  task automatic test_blank();
    int k;
    int f;
    logic [15:0] w;
    logic [3:0]  e_an;
    logic [6:0]  e_seg;
    do begin
      blank = (cyc >= 32 && cyc < 48);
      wr_en = (cyc == 33); data = 16'hC0DE;
`ifdef SEVSEG_DP_EN
      dp_in = 4'b0100;
`endif
      @(negedge clk); k = cyc; f = (k - 1) / 16;
      w = (f >= 3) ? 16'hC0DE : 16'h0000;
      e_an  = (f == 2) ? 4'hF : exp_an(k);
      e_seg = (f == 2) ? 7'h7F : exp_seg(k, w);
      checks++; if (an !== e_an) begin errors++; $display("[TB] FAIL blank_an k=%0d got=%h exp=%h", k, an, e_an); end
      checks++; if (seg !== e_seg) begin errors++; $display("[TB] FAIL blank_seg k=%0d got=%h exp=%h", k, seg, e_seg); end
      checks++; if (frame_tick !== exp_ft(k)) begin errors++; $display("[TB] FAIL blank_ft k=%0d got=%b exp=%b", k, frame_tick, exp_ft(k)); end
`ifdef SEVSEG_DP_EN
      checks++;
      if (dp !== !(f == 3 && (k - 1) % 4 != 0 && ((k - 1) / 4) % 4 == 2)) begin
        errors++; $display("[TB] FAIL dp k=%0d got=%b", k, dp);
      end
`endif
    end while (k < 64);
    wr_en = 1'b0;
    blank = 1'b0;
  endtask

  initial begin
    test_reset();
    test_idle_scan();
    test_write_mid_frame();
    test_two_writes();
    test_back_to_back();
    test_async_reset();
    test_blank();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
